// File: rtl/nes_controller_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nes_controller_reader: drives NES latch/pulse strobes, shifts in 8 buttons.
// Revision 1.0
// ----------------------------------------------------------------------------
module nes_controller_reader #(
   parameter int HALF_PERIOD = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       nesData,
   output logic       nesLatch,
   output logic       nesPulse,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       busy
);

   localparam int PW = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic          half_q, half_d;
   logic [7:0]    shift_q, shift_d;
   logic          sync1_q, sync2_q;
   logic          latch_q, latch_d;
   logic          pulse_q, pulse_d;
   logic [7:0]    buttons_q, buttons_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          tick;

   assign tick = (presc_q == PW'(HALF_PERIOD - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      half_d  = half_q;
      shift_d = shift_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LATCH;
               idx_d   = 3'd0;
               half_d  = 1'b0;
            end
         end
         LATCH: begin
            // Latch spans two ticks; half_q marks the first one as done.
            if (tick) begin
               if (half_q) state_d = LOW;
               else        half_d  = 1'b1;
            end
         end
         LOW: begin
            if (tick) begin
               shift_d[idx_q] = ~sync2_q;
               state_d        = (idx_q == 3'd7) ? DONE : HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               idx_d   = idx_q + 3'd1;
               state_d = LOW;
            end
         end
         DONE: begin
            // A held start chains straight into the next frame.
            if (start) begin
               state_d = LATCH;
               idx_d   = 3'd0;
               half_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q || tick || state_q == IDLE || state_q == DONE)
         presc_d = '0;
      else
         presc_d = presc_q + PW'(1);

      latch_d   = (state_d == LATCH);
      pulse_d   = (state_d == HIGH);
      busy_d    = (state_d == LATCH) || (state_d == LOW) || (state_d == HIGH);
      valid_d   = (state_d == DONE);
      buttons_d = valid_d ? shift_d : buttons_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         idx_q     <= 3'd0;
         half_q    <= 1'b0;
         shift_q   <= 8'h00;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         latch_q   <= 1'b0;
         pulse_q   <= 1'b0;
         buttons_q <= 8'h00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         half_q    <= half_d;
         shift_q   <= shift_d;
         sync1_q   <= nesData;
         sync2_q   <= sync1_q;
         latch_q   <= latch_d;
         pulse_q   <= pulse_d;
         buttons_q <= buttons_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign nesLatch = latch_q;
   assign nesPulse = pulse_q;
   assign buttons  = buttons_q;
   assign valid    = valid_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_controller_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nes_controller_reader: frame timing and button capture against a pad model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_nes_controller_reader;

   localparam int HP = 4;
   localparam int FRAME = 17 * HP;

   logic       clk;
   logic       reset;
   logic       start;
   logic       nesData;
   logic       nesLatch;
   logic       nesPulse;
   logic [7:0] buttons;
   logic       valid;
   logic       busy;

   int checks;
   int failures;

   nes_controller_reader #(.HALF_PERIOD(HP)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .nesData  (nesData),
      .nesLatch (nesLatch),
      .nesPulse (nesPulse),
      .buttons  (buttons),
      .valid    (valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Controller pad model: latch reloads, each pulse rising edge advances one bit.
   logic [7:0] pressed;
   int         mode;   // 0 = pad model, 1 = tied high, 2 = tied low
   int         bitpos;
   logic       pulse_prev;

   initial begin
      nesData    = 1'b1;
      bitpos     = 0;
      pulse_prev = 1'b0;
      pressed    = 8'h00;
      mode       = 0;
   end

   always @(negedge clk) begin
      if (nesLatch) bitpos = 0;
      else if (nesPulse && !pulse_prev) bitpos = bitpos + 1;
      pulse_prev = nesPulse;
      case (mode)
         1:       nesData = 1'b1;
         2:       nesData = 1'b0;
         default: nesData = (bitpos < 8) ? ~pressed[bitpos] : 1'b1;
      endcase
   end

   logic valid_prev;
   initial valid_prev = 1'b0;
   always @(negedge clk) begin
      check("latch_pulse_exclusive", {31'd0, nesLatch & nesPulse}, 32'd0);
      check("valid_not_consecutive", {31'd0, valid & valid_prev}, 32'd0);
      valid_prev = valid;
   end

   // Expected waveform, cycle c counted from the edge that accepted start.
   function automatic bit exp_latch(int c);
      return (c >= 1) && (c <= 2 * HP);
   endfunction
   function automatic bit exp_busy(int c);
      return (c >= 1) && (c <= FRAME);
   endfunction
   function automatic bit exp_pulse(int c);
      return (c > 2 * HP) && (c <= FRAME) && ((((c - 2 * HP - 1) / HP) % 2) == 1);
   endfunction
   function automatic bit exp_valid(int c);
      return c == FRAME + 1;
   endfunction

   task automatic run_frame(input bit spurious, input logic [7:0] exp_b);
      int m_busy, m_latch, m_pulse, m_valid, n_valid, rises;
      logic prev_p;
      m_busy = 0; m_latch = 0; m_pulse = 0; m_valid = 0; n_valid = 0; rises = 0;
      prev_p = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= FRAME + 2; c++) begin
         @(negedge clk);
         start = spurious && (c == 10 || c == 40);
         if (busy     !== exp_busy(c))  m_busy++;
         if (nesLatch !== exp_latch(c)) m_latch++;
         if (nesPulse !== exp_pulse(c)) m_pulse++;
         if (valid    !== exp_valid(c)) m_valid++;
         if (valid) n_valid++;
         if (nesPulse && !prev_p) rises++;
         prev_p = nesPulse;
         if (c == FRAME + 1) check("buttons_at_valid", {24'd0, buttons}, {24'd0, exp_b});
         if (c == FRAME + 2) check("buttons_hold", {24'd0, buttons}, {24'd0, exp_b});
      end
      start = 1'b0;
      check("busy_trace_mismatches", m_busy, 0);
      check("latch_trace_mismatches", m_latch, 0);
      check("pulse_trace_mismatches", m_pulse, 0);
      check("valid_trace_mismatches", m_valid, 0);
      check("valid_count", n_valid, 1);
      check("pulse_count", rises, 7);
   endtask

   typedef struct {
      logic [7:0] pressed;
      int         mode;
      bit         spurious;
      logic [7:0] exp_b;
   } vec_t;

   vec_t vecs[6];
   int   vcount[$];
   int   cyc;
   int   m_idle;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{8'h49, 0, 1'b0, 8'h49};
      vecs[1] = '{8'h00, 1, 1'b0, 8'h00};
      vecs[2] = '{8'h00, 2, 1'b0, 8'hFF};
      vecs[3] = '{8'hA5, 0, 1'b1, 8'hA5};
      vecs[4] = '{8'h80, 0, 1'b0, 8'h80};
      vecs[5] = '{8'h01, 0, 1'b1, 8'h01};

      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_latch", {31'd0, nesLatch}, 0);
      check("reset_pulse", {31'd0, nesPulse}, 0);
      check("reset_valid", {31'd0, valid}, 0);
      check("reset_buttons", {24'd0, buttons}, 0);

      // First start is taken on the very edge that sees reset released.
      reset = 1'b1;
      pressed = 8'h49; mode = 0;
      run_frame(1'b0, 8'h49);

      foreach (vecs[i]) begin
         pressed = vecs[i].pressed;
         mode    = vecs[i].mode;
         run_frame(vecs[i].spurious, vecs[i].exp_b);
      end

      for (int i = 0; i < 8; i++) begin
         pressed = 8'($urandom);
         mode    = 0;
         run_frame(1'($urandom_range(0, 1)), pressed);
      end

      // Mid-frame reset after a 0x49 read.
      pressed = 8'h49; mode = 0;
      run_frame(1'b0, 8'h49);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 30; c++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_busy", {31'd0, busy}, 0);
      check("midreset_latch", {31'd0, nesLatch}, 0);
      check("midreset_pulse", {31'd0, nesPulse}, 0);
      check("midreset_valid", {31'd0, valid}, 0);
      check("midreset_buttons", {24'd0, buttons}, 0);
      reset = 1'b1;
      m_idle = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (valid || busy || buttons != 8'h00) m_idle++;
      end
      check("post_abort_quiet", m_idle, 0);
      run_frame(1'b0, 8'h49);

      // Held start: back-to-back frames.
      pressed = 8'h3C; mode = 0;
      start = 1'b1;
      cyc = 0;
      m_idle = 0;
      while (vcount.size() < 3 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (valid_prev_seen(cyc)) m_idle++;
         if (valid) begin
            vcount.push_back(cyc);
            if (vcount.size() == 3) start = 1'b0;
         end
      end
      check("chained_valid_count", vcount.size(), 3);
      if (vcount.size() == 3) begin
         check("chained_period_1", vcount[1] - vcount[0], FRAME + 1);
         check("chained_period_2", vcount[2] - vcount[1], FRAME + 1);
      end
      check("chained_latch_after_done", m_idle, 0);
      check("chained_buttons", {24'd0, buttons}, 32'h3C);
      @(negedge clk);
      check("chained_stop_busy", {31'd0, busy}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Counts violations of "nesLatch high the cycle after a valid" while chaining.
   logic last_valid;
   initial last_valid = 1'b0;
   function automatic bit valid_prev_seen(int c);
      bit bad;
      bad = (c > 1) && last_valid && (vcount.size() < 3) && !nesLatch;
      last_valid = valid;
      return bad;
   endfunction

endmodule
`default_nettype wire

// File: doc/nes_controller_reader.md
NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 Parameter HALF_PERIOD, default 300, clk cycles per protocol tick (legal range 4..4095).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on posedge clk only.
REQ-003 reset  input  1  synchronous, active-low reset (low = reset, sampled on posedge clk).
REQ-004 start  input  1  request one controller read; sampled only in IDLE.
REQ-005 nesData  input  1  controller serial data; asynchronous, active-low (0 = pressed).
REQ-006 nesLatch  output  1  controller latch strobe, active-high, registered.
REQ-007 nesPulse  output  1  controller shift clock, active-high, registered.
REQ-008 buttons  output  8  last completed read, 1 = pressed; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-009 valid  output  1  one-cycle strobe; buttons updated this cycle.
REQ-010 busy  output  1  high from accepted start until read completes.

Function
REQ-011 nesData SHALL pass through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-012 A prescaler SHALL count 0..HALF_PERIOD-1, raise an internal tick on terminal count, and clear to 0 on every state transition.
REQ-013 FSM states SHALL be IDLE, LATCH, LOW, HIGH, DONE; unreachable encodings SHALL return to IDLE.
REQ-014 IDLE: start=1 -> LATCH, bit index cleared to 0, busy=1 next cycle; start=0 -> stay.
REQ-015 LATCH: nesLatch=1 for exactly 2 ticks (2*HALF_PERIOD cycles), then -> LOW.
REQ-016 LOW: nesLatch=0, nesPulse=0 for 1 tick; on the tick edge the inverted synchronized data SHALL be written to shift-register bit [index].
REQ-017 LOW tick with index<7 -> HIGH; with index=7 -> DONE.
REQ-018 HIGH: nesPulse=1 for 1 tick; on the tick edge index increments and state -> LOW.
REQ-019 DONE: buttons loaded from shift register, valid=1, busy=0, all for exactly that one cycle; -> IDLE next edge.
REQ-020 Frame length SHALL be 17*HALF_PERIOD cycles of busy plus the DONE cycle; exactly 7 nesPulse high periods per frame.
REQ-021 start asserted while busy SHALL be ignored (not queued); start held high in IDLE after DONE SHALL launch a new frame immediately.
REQ-022 buttons SHALL hold their value between DONE cycles; a partial frame SHALL never alter buttons.
REQ-023 nesLatch and nesPulse SHALL never be high in the same cycle.
REQ-024 Index is 3 bits; no wrap beyond 7 occurs because the index=7 LOW tick exits to DONE.

Reset
REQ-025 reset=0 at any posedge SHALL force next cycle: state IDLE, prescaler 0, index 0, shift register 0, nesLatch 0, nesPulse 0, buttons 0x00, valid 0, busy 0.
REQ-026 reset mid-frame SHALL abort the frame with no valid strobe and buttons cleared to 0x00.
REQ-027 After reset release, the first start SHALL be accepted on the first posedge with reset=1.

Verification (HALF_PERIOD=4)
REQ-028 Reset, start pulse at edge k -> busy high cycles k+1..k+68, nesLatch high cycles k+1..k+8, 7 nesPulse pulses of 4 cycles, valid high in cycle k+69.
REQ-029 Model drives A,Start,Left pressed (data low on bits 0,3,6) -> buttons=0x49 with valid; nesData tied 1 -> buttons=0x00; tied 0 -> 0xFF.
REQ-030 start pulsed again at cycles k+10 and k+40 during frame -> no effect on timing; exactly one valid per frame.
REQ-031 reset=0 at cycle k+30 after a prior read of 0x49 -> next cycle all outputs 0, buttons 0x00, no valid; new start yields full frame.
REQ-032 start held high continuously -> back-to-back frames, nesLatch rises the cycle after each DONE, valid every 69 cycles.
REQ-033 Assertion throughout all tests: never (nesLatch && nesPulse); valid never high for 2 consecutive cycles.
